// File: rtl/gnr_node_lut.sv
// rtl/gnr_node_lut.sv - Boolean-network node: programmable truth table with two update tracks
// Track 0 updates through a strobe divider, track 1 on every strobe; both count changes and detect steady state.
module gnr_node_lut #(
    parameter int N_IN      = 4,
    parameter int PERIOD_S0 = 2,
    parameter int CNT_W     = 8,
    parameter int STABLE_N  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reset_nos,
    input  logic                 init_state,
    input  logic                 start_s0,
    input  logic                 start_s1,
    input  logic [N_IN-1:0]      in_s0,
    input  logic [N_IN-1:0]      in_s1,
    input  logic                 lut_we,
    input  logic [2**N_IN-1:0]   lut_data,
    output logic                 s0,
    output logic                 s1,
    output logic                 node_s0,
    output logic                 node_s1,
    output logic [CNT_W-1:0]     chg_s0,
    output logic [CNT_W-1:0]     chg_s1,
    output logic                 stable_s0,
    output logic                 stable_s1
);

    localparam int LUT_D = 2**N_IN;
    localparam int DIV_W = (PERIOD_S0 > 1) ? $clog2(PERIOD_S0) : 1;
    localparam int RUN_W = $clog2(STABLE_N + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PERIOD_S0 - 1);
    localparam logic [CNT_W-1:0] CHG_MAX  = '1;
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STABLE_N);

    logic [LUT_D-1:0]            lut_q, lut_d;
    logic [DIV_W-1:0]            div_q, div_d;
    logic [1:0]                  s_q, s_d;
    logic [1:0][CNT_W-1:0]       chg_q, chg_d;
    logic [1:0][RUN_W-1:0]       run_q, run_d;
    logic [1:0]                  stable_q, stable_d;
    logic [1:0]                  upd;
    logic [1:0]                  nxt;

    always_comb begin
        lut_d    = lut_we ? lut_data : lut_q;
        div_d    = div_q;
        s_d      = s_q;
        chg_d    = chg_q;
        run_d    = run_q;
        stable_d = stable_q;
        upd[0]   = start_s0 && (div_q == DIV_LAST);
        upd[1]   = start_s1;
        // Evaluation reads the registered table, so a same-cycle write is not yet visible.
        nxt[0]   = lut_q[in_s0];
        nxt[1]   = lut_q[in_s1];

        if (reset_nos) begin
            s_d      = {2{init_state}};
            div_d    = DIV_LAST;
            chg_d    = '0;
            run_d    = '0;
            stable_d = '0;
        end else begin
            if (start_s0) begin
                div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            end
            for (int t = 0; t < 2; t++) begin
                if (upd[t]) begin
                    s_d[t] = nxt[t];
                    if (nxt[t] != s_q[t]) begin
                        chg_d[t]    = (chg_q[t] == CHG_MAX) ? chg_q[t] : chg_q[t] + 1'b1;
                        run_d[t]    = '0;
                        stable_d[t] = 1'b0;
                    end else begin
                        run_d[t]    = (run_q[t] >= RUN_MAX) ? RUN_MAX : run_q[t] + 1'b1;
                        stable_d[t] = (run_q[t] >= RUN_MAX - 1'b1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lut_q    <= '0;
            div_q    <= DIV_LAST;
            s_q      <= '0;
            chg_q    <= '0;
            run_q    <= '0;
            stable_q <= '0;
        end else begin
            lut_q    <= lut_d;
            div_q    <= div_d;
            s_q      <= s_d;
            chg_q    <= chg_d;
            run_q    <= run_d;
            stable_q <= stable_d;
        end
    end

    assign s0        = s_q[0];
    assign s1        = s_q[1];
    assign node_s0   = s_q[0];
    assign node_s1   = s_q[1];
    assign chg_s0    = chg_q[0];
    assign chg_s1    = chg_q[1];
    assign stable_s0 = stable_q[0];
    assign stable_s1 = stable_q[1];

endmodule

// File: tb/tb_gnr_node_lut.sv
// tb/tb_gnr_node_lut.sv - directed self-checking bench for gnr_node_lut
// Instance a uses default parameters; instance b uses PERIOD_S0=3, CNT_W=3 and shares all inputs.
module tb_gnr_node_lut;

    logic        clk;
    logic        rst;
    logic        reset_nos;
    logic        init_state;
    logic        start_s0;
    logic        start_s1;
    logic [3:0]  in_s0;
    logic [3:0]  in_s1;
    logic        lut_we;
    logic [15:0] lut_data;

    logic       a_s0, a_s1, a_ns0, a_ns1, a_st0, a_st1;
    logic [7:0] a_chg0, a_chg1;
    logic       b_s0, b_s1, b_ns0, b_ns1, b_st0, b_st1;
    logic [2:0] b_chg0, b_chg1;

    int passed = 0;
    int total  = 0;
    logic exp_s;

    gnr_node_lut #(.N_IN(4), .PERIOD_S0(2), .CNT_W(8), .STABLE_N(4)) dut_a (
        .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state),
        .start_s0(start_s0), .start_s1(start_s1), .in_s0(in_s0), .in_s1(in_s1),
        .lut_we(lut_we), .lut_data(lut_data),
        .s0(a_s0), .s1(a_s1), .node_s0(a_ns0), .node_s1(a_ns1),
        .chg_s0(a_chg0), .chg_s1(a_chg1), .stable_s0(a_st0), .stable_s1(a_st1)
    );

    gnr_node_lut #(.N_IN(4), .PERIOD_S0(3), .CNT_W(3), .STABLE_N(4)) dut_b (
        .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state),
        .start_s0(start_s0), .start_s1(start_s1), .in_s0(in_s0), .in_s1(in_s1),
        .lut_we(lut_we), .lut_data(lut_data),
        .s0(b_s0), .s1(b_s1), .node_s0(b_ns0), .node_s1(b_ns1),
        .chg_s0(b_chg0), .chg_s1(b_chg1), .stable_s0(b_st0), .stable_s1(b_st1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic a, input logic b);
        start_s0 = a;
        start_s1 = b;
        tick();
        start_s0 = 1'b0;
        start_s1 = 1'b0;
    endtask

    task automatic renos(input logic v);
        init_state = v;
        reset_nos  = 1'b1;
        tick();
        reset_nos  = 1'b0;
    endtask

    task automatic wlut(input logic [15:0] d);
        lut_data = d;
        lut_we   = 1'b1;
        tick();
        lut_we   = 1'b0;
    endtask

    initial begin
        rst = 1'b0; reset_nos = 0; init_state = 0; start_s0 = 0; start_s1 = 0;
        in_s0 = '0; in_s1 = '0; lut_we = 0; lut_data = '0;
        #2;
        chk("rst_s0", a_s0, 0);
        chk("rst_s1", a_s1, 0);
        chk("rst_chg0", a_chg0, 0);
        chk("rst_stable1", a_st1, 0);
        tick();
        rst = 1'b1;
        tick();

        // identity table: next = in bit0
        wlut(16'hAAAA);
        renos(1'b1);
        chk("id_init_s0", a_s0, 1);
        chk("id_init_s1", a_ns1, 1);
        strobe(1, 0);
        chk("id_strobe1_s0", a_s0, 0);
        chk("id_strobe1_chg0", a_chg0, 1);
        strobe(1, 0);
        strobe(1, 0);
        strobe(1, 0);
        chk("id_strobe4_s0", a_ns0, 0);
        chk("id_strobe4_chg0", a_chg0, 1);
        strobe(0, 1);
        chk("id_s1", a_s1, 0);
        chk("id_chg1", a_chg1, 1);

        // divider on instance b, constant-one table
        wlut(16'hFFFF);
        renos(1'b0);
        strobe(1, 0);
        chk("div_strobe1_s0", b_s0, 1);
        chk("div_strobe1_chg0", b_chg0, 1);
        strobe(1, 0);
        strobe(1, 0);
        strobe(1, 0);
        chk("div_strobe4_stable", b_st0, 0);
        strobe(1, 0);
        strobe(1, 0);
        chk("div_strobe6_chg0", b_chg0, 1);
        for (int i = 7; i <= 12; i++) strobe(1, 0);
        chk("div_strobe12_stable", b_st0, 0);
        strobe(1, 0);
        chk("div_strobe13_stable", b_st0, 1);
        chk("div_strobe13_chg0", b_chg0, 1);

        // oscillation: next = NOT in bit0, fed back from s1
        wlut(16'h5555);
        renos(1'b0);
        exp_s = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_s1 = {3'b000, a_s1};
            strobe(0, 1);
            exp_s = ~exp_s;
            chk("osc_s1", a_s1, exp_s);
        end
        chk("osc_chg1", a_chg1, 10);
        chk("osc_stable1", a_st1, 0);
        chk("sat_b_chg1_10", b_chg1, 7);
        for (int i = 0; i < 2; i++) begin
            in_s1 = {3'b000, a_s1};
            strobe(0, 1);
        end
        chk("osc_chg1_12", a_chg1, 12);
        chk("sat_b_chg1_12", b_chg1, 7);

        // break feedback: table gives 1 for input 0
        in_s1 = '0;
        strobe(0, 1);
        chk("brk_s1", a_s1, 1);
        chk("brk_chg1", a_chg1, 13);
        strobe(0, 1);
        strobe(0, 1);
        strobe(0, 1);
        chk("brk_stable_3", a_st1, 0);
        strobe(0, 1);
        chk("brk_stable_4", a_st1, 1);

        // lut write collides with a strobe: old table wins
        renos(1'b0);
        in_s1    = '0;
        lut_data = 16'hAAAA;
        lut_we   = 1'b1;
        strobe(0, 1);
        lut_we   = 1'b0;
        chk("coll_lut_old", a_s1, 1);
        strobe(0, 1);
        chk("coll_lut_new", a_s1, 0);

        // reset_nos with both strobes: strobes ignored
        init_state = 1'b1;
        reset_nos  = 1'b1;
        strobe(1, 1);
        reset_nos  = 1'b0;
        chk("coll_nos_s0", a_s0, 1);
        chk("coll_nos_s1", a_s1, 1);
        chk("coll_nos_chg1", a_chg1, 0);
        chk("coll_nos_stable1", a_st1, 0);
        strobe(1, 0);
        chk("coll_nos_div_reload", a_s0, 0);

        // async reset mid-count
        wlut(16'h5555);
        renos(1'b0);
        for (int i = 0; i < 9; i++) begin
            in_s0 = {3'b000, a_s0};
            strobe(1, 0);
        end
        chk("pre_rst_chg0", a_chg0, 5);
        chk("pre_rst_s0", a_s0, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_s0", a_s0, 0);
        chk("async_chg0", a_chg0, 0);
        chk("async_stable0", a_st0, 0);
        tick();
        rst = 1'b1;
        in_s0 = 4'h1;
        strobe(1, 0);
        chk("post_rst_s0", a_s0, 0);
        wlut(16'hFFFF);
        strobe(1, 0);
        chk("post_rst_hold", a_s0, 0);
        strobe(1, 0);
        chk("post_rst_update", a_s0, 1);
        chk("post_rst_chg0", a_chg0, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
